// File: rtl/usm_playback.sv
// Table-driven target generator for the ultrasonic motor channel.
// CPU fills a BRAM table; on run the entries are replayed one every intv cycles.
module usm_playback #(
    parameter int unsigned BRAM_DEPTH = 1024,
    parameter int unsigned ADDR_WID   = 10,
    parameter int unsigned DATA_WID   = 32,
    parameter int unsigned INTV_WID   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_reg_usm_play_wr,
    input  logic [ADDR_WID-1:0] i_reg_usm_play_wr_addr,
    input  logic [DATA_WID-1:0] i_reg_usm_play_wr_data,
    input  logic [ADDR_WID:0]   i_reg_usm_play_len,
    input  logic [INTV_WID-1:0] i_reg_usm_play_intv,
    input  logic                i_reg_usm_play_run,
    input  logic                i_reg_usm_play_loop,
    output logic [DATA_WID-1:0] o_usm_target_pulse,
    output logic                o_usm_target_vald,
    output logic [ADDR_WID:0]   o_usm_play_index,
    output logic                o_usm_play_busy,
    output logic                o_usm_play_done,
    output logic                o_reg_usm_play_wr_ack
);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StHold, StDone} state_e;

    localparam logic [ADDR_WID:0]   MaxLen  = (ADDR_WID + 1)'(BRAM_DEPTH);
    localparam logic [INTV_WID-1:0] MinIntv = INTV_WID'(3);

    state_e              state_q, state_d;
    logic                run_r, wr_r;
    logic                run_rise, wr_rise;
    logic [ADDR_WID-1:0] raddr_q, raddr_d;
    logic [ADDR_WID:0]   index_q, index_d;
    logic [INTV_WID-1:0] intv_cnt_q, intv_cnt_d;
    logic [DATA_WID-1:0] target_q, target_d;
    logic                vald_q, vald_d;
    logic                done_q, done_d;
    logic                ack_q;
    logic [ADDR_WID:0]   eff_len;
    logic [INTV_WID-1:0] eff_intv;
    logic                hold_last;

    logic [DATA_WID-1:0] mem [BRAM_DEPTH];
    logic [DATA_WID-1:0] dout;

    assign run_rise  = i_reg_usm_play_run & ~run_r;
    assign wr_rise   = i_reg_usm_play_wr & ~wr_r;
    assign eff_len   = (i_reg_usm_play_len > MaxLen) ? MaxLen : i_reg_usm_play_len;
    assign eff_intv  = (i_reg_usm_play_intv < MinIntv) ? MinIntv : i_reg_usm_play_intv;
    assign hold_last = (intv_cnt_q == eff_intv - MinIntv);

    // Read-first simple dual-port table; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_rise) begin
            mem[i_reg_usm_play_wr_addr] <= i_reg_usm_play_wr_data;
        end
        dout <= mem[raddr_q];
    end

    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        index_d    = index_q;
        intv_cnt_d = intv_cnt_q;
        target_d   = target_q;
        vald_d     = 1'b0;
        done_d     = done_q;
        case (state_q)
            StIdle: begin
                if (run_rise) begin
                    done_d  = 1'b0;
                    index_d = '0;
                    if (eff_len == '0) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        raddr_d = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                state_d = i_reg_usm_play_run ? StLoad : StIdle;
            end
            StLoad: begin
                if (!i_reg_usm_play_run) begin
                    state_d = StIdle;
                end else begin
                    target_d   = dout;
                    vald_d     = 1'b1;
                    index_d    = index_q + (ADDR_WID + 1)'(1);
                    intv_cnt_d = '0;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (!i_reg_usm_play_run) begin
                    state_d = StIdle;
                end else if (hold_last) begin
                    if (index_q < eff_len) begin
                        raddr_d = raddr_q + ADDR_WID'(1);
                        state_d = StFetch;
                    end else if (i_reg_usm_play_loop) begin
                        raddr_d = '0;
                        index_d = '0;
                        state_d = StFetch;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else begin
                    intv_cnt_d = intv_cnt_q + INTV_WID'(1);
                end
            end
            StDone: begin
                if (!i_reg_usm_play_run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            // Treat run as already high so a level held through reset cannot start playback.
            run_r      <= 1'b1;
            wr_r       <= 1'b0;
            raddr_q    <= '0;
            index_q    <= '0;
            intv_cnt_q <= '0;
            target_q   <= '0;
            vald_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_r      <= i_reg_usm_play_run;
            wr_r       <= i_reg_usm_play_wr;
            raddr_q    <= raddr_d;
            index_q    <= index_d;
            intv_cnt_q <= intv_cnt_d;
            target_q   <= target_d;
            vald_q     <= vald_d;
            done_q     <= done_d;
            ack_q      <= wr_rise;
        end
    end

    assign o_usm_target_pulse    = target_q;
    assign o_usm_target_vald     = vald_q;
    assign o_usm_play_index      = index_q;
    assign o_usm_play_busy       = (state_q == StFetch) || (state_q == StLoad) ||
                                   (state_q == StHold);
    assign o_usm_play_done       = done_q;
    assign o_reg_usm_play_wr_ack = ack_q;

endmodule

// File: tb/tb_usm_playback.sv
// Randomized self-checking bench for usm_playback against an arithmetic schedule model.
module tb_usm_playback;

    localparam int Depth = 1024;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int IW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   len = '0;
    logic [IW-1:0] intv = '0;
    logic          run = 1'b0;
    logic          loop_en = 1'b0;
    logic [DW-1:0] target;
    logic          vald;
    logic [AW:0]   index;
    logic          busy;
    logic          done;
    logic          ack;

    usm_playback #(
        .BRAM_DEPTH (Depth),
        .ADDR_WID   (AW),
        .DATA_WID   (DW),
        .INTV_WID   (IW)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_reg_usm_play_wr      (wr),
        .i_reg_usm_play_wr_addr (wr_addr),
        .i_reg_usm_play_wr_data (wr_data),
        .i_reg_usm_play_len     (len),
        .i_reg_usm_play_intv    (intv),
        .i_reg_usm_play_run     (run),
        .i_reg_usm_play_loop    (loop_en),
        .o_usm_target_pulse     (target),
        .o_usm_target_vald      (vald),
        .o_usm_play_index       (index),
        .o_usm_play_busy        (busy),
        .o_usm_play_done        (done),
        .o_reg_usm_play_wr_ack  (ack)
    );

    always #5 clk = ~clk;

    int unsigned   table_m [Depth];
    logic [DW-1:0] tgt_m;
    int            n_vec;
    int            n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr_entry(input int addr, input int unsigned data, input int hold);
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        table_m[addr] = data;
        @(negedge clk);
        chk("wr_ack", ack, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("wr_ack_held", ack, 0);
        end
        wr = 1'b0;
    endtask

    // Expected schedule relative to the run edge k (t = cycle - k): output j appears at
    // t = 3 + j*I, done from t = 1 + L*I, and a FETCH at t-2 sees writes issued before it.
    task automatic play(input int len_in, input int intv_in, input bit loop_in, input int max_t,
                        input int drop_t, input int wr_t, input int wr_a, input int unsigned wr_d,
                        input int rst_t);
        int            L, I, j, idx;
        bit            done_e, busy_e, vald_e, wr_issued, do_rst;
        logic [DW-1:0] d_e;
        L = (len_in > Depth) ? Depth : len_in;
        I = (intv_in < 3) ? 3 : intv_in;
        done_e    = 1'b0;
        wr_issued = 1'b0;
        do_rst    = 1'b0;
        @(negedge clk);
        run     = 1'b0;
        len     = (AW + 1)'(len_in);
        intv    = intv_in;
        loop_en = loop_in;
        @(negedge clk);
        run = 1'b1;
        for (int t = 1; t <= max_t; t++) begin
            @(negedge clk);
            vald_e = 1'b0;
            d_e    = tgt_m;
            idx    = 0;
            if (L == 0) begin
                done_e = 1'b1;
                busy_e = 1'b0;
            end else begin
                done_e = !loop_in && (t >= 1 + L * I);
                busy_e = !done_e;
                if (t >= 3 && (t - 3) % I == 0) begin
                    j = (t - 3) / I;
                    if (loop_in || j < L) begin
                        vald_e = 1'b1;
                        idx    = j % L;
                        d_e    = table_m[idx];
                        if (wr_t > 0 && wr_a == idx && wr_t < t - 2) d_e = wr_d;
                    end
                end
            end
            chk("vald", vald, vald_e);
            chk("busy", busy, busy_e);
            chk("done", done, done_e);
            chk("target", target, d_e);
            if (vald_e) chk("index", index, idx + 1);
            if (done_e && L > 0) chk("index_done", index, L);
            if (wr_t > 0 && t == wr_t + 1) chk("wr_ack_play", ack, 1);
            else chk("no_ack", ack, 0);
            tgt_m = d_e;
            if (t == wr_t) begin
                wr        = 1'b1;
                wr_addr   = AW'(wr_a);
                wr_data   = wr_d;
                wr_issued = 1'b1;
            end
            if (t == wr_t + 1) wr = 1'b0;
            if (t == rst_t) begin
                do_rst = 1'b1;
                break;
            end
            if (t == drop_t) break;
        end
        if (wr_issued) table_m[wr_a] = wr_d;
        if (do_rst) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_target", target, 0);
            chk("rst_vald", vald, 0);
            chk("rst_index", index, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ack", ack, 0);
            tgt_m = '0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("post_rst_busy", busy, 0);
                chk("post_rst_vald", vald, 0);
                chk("post_rst_done", done, 0);
            end
        end else begin
            run = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("stop_vald", vald, 0);
                chk("stop_busy", busy, 0);
                chk("stop_done", done, done_e);
                chk("stop_target", target, tgt_m);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int L, I, mt, dt;
        bit lp;
        n_vec = 0;
        n_err = 0;
        tgt_m = '0;
        repeat (2) @(negedge clk);
        chk("reset_target", target, 0);
        chk("reset_vald", vald, 0);
        chk("reset_index", index, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ack", ack, 0);
        rst_n = 1'b1;

        for (int a = 0; a < 4; a++) wr_entry(a, 100 * (a + 1), 0);
        play(4, 5, 1'b0, 24, 0, 0, 0, 0, 0);
        play(4, 5, 1'b1, 48, 0, 0, 0, 0, 0);
        play(4, 5, 1'b0, 50, 10, 0, 0, 0, 0);
        play(0, 5, 1'b0, 4, 0, 0, 0, 0, 0);
        play(3, 1, 1'b0, 12, 0, 0, 0, 0, 0);

        wr_entry(5, 32'h5555, 3);
        play(4, 5, 1'b0, 24, 0, 2, 2, 999, 0);
        play(4, 5, 1'b0, 100, 0, 0, 0, 0, 4);

        for (int a = 0; a < Depth; a++) wr_entry(a, $urandom, 0);
        play(2000, 3, 1'b0, 1 + Depth * 3 + 2, 0, 0, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                wr_entry(int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 2)));
            end
            L  = int'($urandom_range(0, 8));
            I  = int'($urandom_range(0, 7));
            lp = 1'($urandom_range(0, 1));
            if (L == 0) mt = 3;
            else if (lp) mt = 3 + int'($urandom_range(4, 12)) * ((I < 3) ? 3 : I);
            else mt = 1 + L * ((I < 3) ? 3 : I) + 2;
            dt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, mt)) : 0;
            play(L, I, lp, mt, dt, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usm_playback.md
# usm_playback

Table-driven target generator for the ultrasonic motor (USM) channel and the write-side counterpart of the USM sampler. The CPU loads a table of target pulse positions into an internal BRAM through AXI register writes. On run, the block reads the table back in order and presents one target value every `intv` clock cycles to the motor move logic, either as a single pass or looping.

## Interface

**Parameters**
- `BRAM_DEPTH`, default 1024: number of table entries.
- `ADDR_WID`, default 10: table address width, equal to log2(`BRAM_DEPTH`).
- `DATA_WID`, default 32: width of each target pulse value.
- `INTV_WID`, default 32: width of the interval register.

**Ports** (one clock; reset is asynchronous and active-low)
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_reg_usm_play_wr`  in  1: register write strobe (level). A write is taken on its rising edge.
- `i_reg_usm_play_wr_addr`  in  `ADDR_WID`: table write address.
- `i_reg_usm_play_wr_data`  in  `DATA_WID`: table write data.
- `i_reg_usm_play_len`  in  `ADDR_WID`+1: number of entries to play.
- `i_reg_usm_play_intv`  in  `INTV_WID`: output spacing in cycles.
- `i_reg_usm_play_run`  in  1: run level. Rising edge starts playback; low aborts it.
- `i_reg_usm_play_loop`  in  1: 1 = wrap to entry 0 after the last entry.
- `o_usm_target_pulse`  out  `DATA_WID`: current target value, held between updates.
- `o_usm_target_vald`  out  1: one-cycle pulse marking a new `o_usm_target_pulse`.
- `o_usm_play_index`  out  `ADDR_WID`+1: number of entries issued in the current pass.
- `o_usm_play_busy`  out  1: playback active.
- `o_usm_play_done`  out  1: set when a pass completes; sticky.
- `o_reg_usm_play_wr_ack`  out  1: one-cycle acknowledge of a table write.

## Operation

**Table memory and writes**
- The table is an inferred simple dual-port BRAM with read-first behaviour and 1-cycle read latency.
- Port A: the CPU writes on the rising edge of `i_reg_usm_play_wr`, detected against a registered copy of the strobe.
- Writes are accepted in every state, including during playback.
- A write to the address being read in the same cycle returns the old data.

**Argument handling**
- Effective `len` = min(`i_reg_usm_play_len`, `BRAM_DEPTH`).
- Effective `intv` = max(`i_reg_usm_play_intv`, 3).

**State machine: IDLE, FETCH, LOAD, HOLD, DONE**
- IDLE
  - On a run rising edge, clear `o_usm_play_done` and `o_usm_play_index`.
  - If effective `len` = 0, go to DONE.
  - Otherwise set `raddr` = 0 and go to FETCH.
- FETCH: present `raddr` to the BRAM for one cycle, then go to LOAD.
- LOAD
  - Register BRAM dout into `o_usm_target_pulse`.
  - Pulse `o_usm_target_vald`.
  - Increment `o_usm_play_index`.
  - Clear `intv_cnt`, then go to HOLD.
- HOLD
  - `intv_cnt` counts from 0 to `intv`-3, giving `intv`-2 cycles in HOLD.
  - At the terminal count:
    - If `index` < `len`: `raddr`++, go to FETCH.
    - Else if loop = 1: `raddr` = 0, `index` = 0, go to FETCH.
    - Else: go to DONE.
- DONE: `o_usm_play_done` = 1. Return to IDLE when run is low.

**Status and abort**
- `o_usm_play_busy` = 1 in FETCH, LOAD and HOLD.
- If run is low in FETCH, LOAD or HOLD: go to IDLE on the next edge. `o_usm_play_done` is not set, and `o_usm_target_pulse` keeps its last value.
- Changes to `len`, `intv` or `loop` during playback take effect at the next HOLD terminal count or HOLD entry.

## Timing

**Reset**
- All outputs are 0 and the FSM is in IDLE.
- Table contents are undefined after reset.

**Start latency**
- Let cycle k be the first clock at which run is sampled high with run_r = 0.
- FETCH occurs in k+1 and LOAD in k+2.
- `o_usm_target_vald` is high in cycle k+3 together with entry 0.

**Output spacing**
- Consecutive `vald` pulses are exactly `intv` cycles apart: 1 FETCH + 1 LOAD + (`intv`-2) HOLD.
- In loop mode the spacing is the same across the wrap, from entry `len`-1 to entry 0.

**Completion and abort**
- Non-loop: `o_usm_play_done` rises `intv`-2 cycles after the last `vald`; `busy` falls in the same cycle.
- Abort: `busy` is 0 in the cycle after run is sampled low, and no further `vald` pulses occur.

**Write path**
- `o_reg_usm_play_wr_ack` pulses in the cycle after the write edge is detected.
- The written data is readable by a FETCH starting in the following cycle.

**Restart**
- Run rising again while in DONE requires run to go low first. A held-high run does not restart.

## Test plan

1. Write entries {100, 200, 300, 400} to addresses 0-3 with `len`=4, `intv`=5, `loop`=0, then raise run at cycle k.
   - `vald` at k+3, k+8, k+13, k+18 carrying 100, 200, 300, 400.
   - `index` reads 1 to 4; `done`=1 at k+21; exactly 4 `vald` pulses.
2. Same table with `loop`=1 over 10 outputs.
   - Data sequence 100, 200, 300, 400, 100, …, with a constant 5-cycle spacing including across the wrap.
   - `done` stays 0 throughout.
3. Drop run 2 cycles after the 2nd `vald`.
   - `busy`=0 on the next cycle, `target_pulse` holds 200, `done`=0, and no further `vald` pulses.
4. Boundary arguments:
   - `len`=0: `done`=1 at k+1 with no `vald`.
   - `intv`=1: spacing of 3 cycles.
   - `len`=2000 with `BRAM_DEPTH`=1024: exactly 1024 outputs before `done`.
5. Rewrite address 2 with 999 while playing, before its FETCH.
   - The 3rd output is 999.
   - A write 1 cycle before `wr_ack` produces `wr_ack` once per strobe rising edge; a held strobe gives a single ack.
6. Assert `rst_n` low mid-HOLD.
   - All outputs are 0 immediately (asynchronously).
   - After release with run held high, no playback starts until run toggles low then high.
